// File: rtl/lcd_bus_responder_if.sv
// Parallel character-LCD bus (EN/RS/RW strobes, write data, read-back path).
interface lcd_bus_responder_if;
    localparam int unsigned DW = 8;

    logic          LCD_EN;
    logic          LCD_RS;
    logic          LCD_RW;
    logic [DW-1:0] LCD_DADOS_IN;
    logic [DW-1:0] LCD_DADOS_OUT;
    logic          LCD_DADOS_OE;

    modport master (
        output LCD_EN, LCD_RS, LCD_RW, LCD_DADOS_IN,
        input  LCD_DADOS_OUT, LCD_DADOS_OE
    );

    modport slave (
        input  LCD_EN, LCD_RS, LCD_RW, LCD_DADOS_IN,
        output LCD_DADOS_OUT, LCD_DADOS_OE
    );
endinterface

// File: rtl/lcd_bus_responder.sv
// Character-LCD bus responder: latches transfers on EN fall, decodes the HD44780/ST7032 subset,
// models DDRAM, address counter and busy timer. Optional macro LCD_RESP_BUSY_CHECK_EN.
module lcd_bus_responder #(
    parameter int unsigned CMD_CYCLES   = 2000,
    parameter int unsigned CLEAR_CYCLES = 82000,
    parameter int unsigned DDRAM_DEPTH  = 80
) (
    input  logic               Clock,
    input  logic               Reset,
    lcd_bus_responder_if.slave bus,
    output logic               busy,
    output logic [6:0]         ac,
    output logic [2:0]         disp_ctrl,
    output logic               entry_id,
    output logic               two_lines,
    output logic               cmd_strobe,
    output logic [7:0]         cmd_last,
    output logic               viol,
    input  logic [6:0]         dbg_addr,
    output logic [7:0]         dbg_char
);
    localparam int unsigned AW   = 7;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXC = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DDRAM_DEPTH - 1);
    localparam logic [DW-1:0] SPACE     = DW'(8'h20);

    typedef enum logic [1:0] {ST_READY, ST_CLEAR_FILL, ST_BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;

    logic          en_q, en_q2, rs_q, rs_q2, rw_q, rw_q2;
    logic [DW-1:0] din_q, din_q2;
    logic          xfer_q, xrs_q, xrw_q;
    logic [DW-1:0] xdata_q;

    logic          wr_req, wr_ok, viol_set, instr_ok, data_ok, rd_step;
    logic          is_clear, is_home, fill_we;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem [DDRAM_DEPTH];

    function automatic logic [AW-1:0] ac_step(input logic [AW-1:0] a, input logic inc);
        if (inc) return (a == LAST_ADDR) ? '0 : a + AW'(1);
        return (a == '0) ? LAST_ADDR : a - AW'(1);
    endfunction

    // Pin registers; RS/RW/data travel one stage behind EN so the transfer sees the values held while EN was high.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            en_q    <= 1'b0;
            en_q2   <= 1'b0;
            rs_q    <= 1'b0;
            rs_q2   <= 1'b0;
            rw_q    <= 1'b0;
            rw_q2   <= 1'b0;
            din_q   <= '0;
            din_q2  <= '0;
            xfer_q  <= 1'b0;
            xrs_q   <= 1'b0;
            xrw_q   <= 1'b0;
            xdata_q <= '0;
        end else begin
            en_q    <= bus.LCD_EN;
            rs_q    <= bus.LCD_RS;
            rw_q    <= bus.LCD_RW;
            din_q   <= bus.LCD_DADOS_IN;
            en_q2   <= en_q;
            rs_q2   <= rs_q;
            rw_q2   <= rw_q;
            din_q2  <= din_q;
            xfer_q  <= en_q2 & ~en_q;
            xrs_q   <= rs_q2;
            xrw_q   <= rw_q2;
            xdata_q <= din_q2;
        end
    end

    // Transfer classification and busy-write policy.
    always_comb begin
        wr_req   = xfer_q & ~xrw_q;
`ifdef LCD_RESP_BUSY_CHECK_EN
        wr_ok    = wr_req & ~busy;
        viol_set = wr_req & busy;
`else
        wr_ok    = wr_req;
        viol_set = 1'b0;
`endif
        instr_ok = wr_ok & ~xrs_q;
        data_ok  = wr_ok & xrs_q;
        rd_step  = xfer_q & xrw_q & xrs_q;
        is_clear = (xdata_q == DW'(8'h01));
        is_home  = (xdata_q[DW-1:1] == 7'b0000001);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_CLEAR_FILL;
            cnt_q   <= CW'(DDRAM_DEPTH);
            idx_q   <= '0;
            busy    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy    <= (state_d != ST_READY);
        end
    end

    // Busy timer runs in every non-ready state; the fill always completes before leaving CLEAR_FILL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        fill_we = 1'b0;
        unique case (state_q)
            ST_READY: ;
            ST_CLEAR_FILL: begin
                fill_we = 1'b1;
                idx_d   = idx_q + AW'(1);
                cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
                if (idx_q == LAST_ADDR) state_d = (cnt_q <= CW'(1)) ? ST_READY : ST_BUSY;
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
        if (instr_ok && is_clear) begin
            state_d = ST_CLEAR_FILL;
            idx_d   = '0;
            cnt_d   = CW'(CLEAR_CYCLES);
        end else if (wr_ok) begin
            cnt_d   = (instr_ok && is_home) ? CW'(CLEAR_CYCLES) : CW'(CMD_CYCLES);
            state_d = (state_d == ST_CLEAR_FILL) ? ST_CLEAR_FILL : ST_BUSY;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ac                <= '0;
            disp_ctrl         <= '0;
            entry_id          <= 1'b1;
            two_lines         <= 1'b0;
            cmd_strobe        <= 1'b0;
            cmd_last          <= '0;
            viol              <= 1'b0;
            bus.LCD_DADOS_OUT <= '0;
            bus.LCD_DADOS_OE  <= 1'b0;
        end else begin
            cmd_strobe <= instr_ok;
            if (instr_ok) begin
                cmd_last <= xdata_q;
                if (is_clear) begin
                    ac       <= '0;
                    entry_id <= 1'b1;
                end else if (is_home) begin
                    ac <= '0;
                end else if (xdata_q[7:2] == 6'b000001) begin
                    entry_id <= xdata_q[1];
                end else if (xdata_q[7:3] == 5'b00001) begin
                    disp_ctrl <= xdata_q[2:0];
                end else if (xdata_q[7:5] == 3'b001) begin
                    two_lines <= xdata_q[3];
                end else if (xdata_q[7]) begin
                    ac <= AW'(32'(xdata_q[6:0]) % DDRAM_DEPTH);
                end
            end else if (data_ok || rd_step) begin
                ac <= ac_step(ac, entry_id);
            end
            if (viol_set) viol <= 1'b1;
            bus.LCD_DADOS_OE  <= en_q & rw_q;
            bus.LCD_DADOS_OUT <= !rw_q ? '0 : (rs_q ? mem[ac] : {busy, ac});
        end
    end

    // Single DDRAM write port: bus data write takes priority over the clear fill.
    always_comb begin
        mem_we = data_ok | fill_we;
        mem_wa = data_ok ? ac : idx_q;
        mem_wd = data_ok ? xdata_q : SPACE;
    end

    always_ff @(posedge Clock) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge Clock) begin
        if (Reset) dbg_char <= '0;
        else       dbg_char <= (32'(dbg_addr) < DDRAM_DEPTH) ? mem[dbg_addr] : '0;
    end
endmodule
